// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: start/busy/done handshake and operand/result bus of the
// iterative multiply/divide unit. master = core side, slave = unit side.
`default_nettype none

interface mul_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] opA;
  logic [DATA_WIDTH-1:0] opB;
  logic                  kill;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;

  modport master (
    output start, funct3, opA, opB, kill,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, opA, opB, kill,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU,
// one bit per cycle (shift-add multiply, restoring divide) on magnitudes.
`default_nettype none

module mul_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  mul_div_unit_if.slave   bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2:0]     op;
  logic           neg;
  logic [W-1:0]   oper;
  logic [2*W-1:0] acc, acc_next;
  logic [W-1:0]   result_q, result_next;
  logic           accept, load;

  // Decode of the live request, used only at the accepting edge
  logic         is_div_in, a_signed, b_signed, a_neg, b_neg, sign_in;
  logic         div_zero, overflow, special;
  logic [W-1:0] mag_a, mag_b, special_val;

  assign is_div_in = bus.funct3[2];
  assign a_signed  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd2) ||
                     (bus.funct3 == 3'd4) || (bus.funct3 == 3'd6);
  assign b_signed  = (bus.funct3 == 3'd1) || (bus.funct3 == 3'd4) ||
                     (bus.funct3 == 3'd6);
  assign a_neg     = a_signed & bus.opA[W-1];
  assign b_neg     = b_signed & bus.opB[W-1];
  assign mag_a     = a_neg ? (~bus.opA + 1'b1) : bus.opA;
  assign mag_b     = b_neg ? (~bus.opB + 1'b1) : bus.opB;
  // Remainder follows the dividend; everything else follows the sign product
  assign sign_in   = (bus.funct3 == 3'd6) ? a_neg : (a_neg ^ b_neg);

  assign div_zero    = is_div_in && (bus.opB == '0);
  assign overflow    = ((bus.funct3 == 3'd4) || (bus.funct3 == 3'd6)) &&
                       (bus.opA == SMIN) && (bus.opB == '1);
  assign special     = div_zero || overflow;
  assign special_val = div_zero ? (bus.funct3[1] ? bus.opA : '1)
                                : (bus.funct3[1] ? '0 : SMIN);

  // One iteration. Multiply: acc = {partial, multiplier}, shifted right.
  // Divide: acc = {remainder, dividend/quotient}, shifted left.
  logic [W:0]     sum, shifted, diff;
  logic [2*W-1:0] prod;
  logic [W-1:0]   q_fix, r_fix, final_val;

  assign sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, oper} : {(W+1){1'b0}});
  assign shifted = acc[2*W-1:W-1];
  assign diff    = shifted - {1'b0, oper};

  always_comb begin
    acc_next = acc;
    if (op[2]) begin
      if (diff[W]) acc_next = {shifted[W-1:0], acc[W-2:0], 1'b0};
      else         acc_next = {diff[W-1:0],    acc[W-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[W-1:1]};
    end
  end

  assign prod      = neg ? (~acc_next + 1'b1) : acc_next;
  assign q_fix     = neg ? (~acc_next[W-1:0] + 1'b1) : acc_next[W-1:0];
  assign r_fix     = neg ? (~acc_next[2*W-1:W] + 1'b1) : acc_next[2*W-1:W];
  assign final_val = op[2] ? (op[1] ? r_fix : q_fix)
                           : ((op[1:0] == 2'd0) ? prod[W-1:0] : prod[2*W-1:W]);

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    load        = 1'b0;
    result_next = result_q;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (!bus.kill && bus.start) begin
          accept = 1'b1;
          if (special) begin
            state_next  = DONE;
            load        = 1'b1;
            result_next = special_val;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        if (bus.kill) begin
          state_next = IDLE;
        end else if (cnt == LAST) begin
          state_next  = DONE;
          load        = 1'b1;
          result_next = final_val;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op       <= '0;
      neg      <= 1'b0;
      oper     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      state <= state_next;
      if (load) result_q <= result_next;
      if (accept) begin
        op   <= bus.funct3;
        neg  <= sign_in;
        oper <= is_div_in ? mag_b : mag_a;
        acc  <= {{W{1'b0}}, (is_div_in ? mag_a : mag_b)};
        cnt  <= '0;
      end else if (state == CALC) begin
        acc <= acc_next;
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.busy   = (state == CALC);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors for mul_div_unit with hand-computed results.
`default_nettype none

module tb_mul_div_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mul_div_unit_if #(.DATA_WIDTH(32)) bif ();

  mul_div_unit #(.DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  always #5 clk = ~clk;

  // Issue one op; k counts cycles after the accepting edge (k=1 is the first).
  // At k==inj_at a competing DIVU 100/7 start is driven, at k==kill_at kill.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_at, input int kill_at,
                        output logic [31:0] res, output int lat, output int bcnt);
    int k;
    @(negedge clk);
    bif.start = 1'b1; bif.funct3 = f; bif.opA = a; bif.opB = b;
    @(posedge clk); #1;
    bif.start = 1'b0; bif.funct3 = ~f; bif.opA = ~a; bif.opB = ~b;
    k = 1; lat = -1; bcnt = 0; res = 32'hxxxxxxxx;
    while (k <= 60) begin
      if (bif.busy) bcnt++;
      if (bif.done) begin
        lat = k; res = bif.result;
        break;
      end
      bif.start = (k == inj_at);
      if (k == inj_at) begin
        bif.funct3 = 3'd5; bif.opA = 32'd100; bif.opB = 32'd7;
      end
      bif.kill = (k == kill_at);
      @(posedge clk); #1;
      k++;
    end
    bif.start = 1'b0; bif.kill = 1'b0;
  endtask

  task automatic test_reset();
    bif.start = 1'b0; bif.kill = 1'b0; bif.funct3 = 3'd0; bif.opA = '0; bif.opB = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b result=%h, expected 0 0 00000000",
               bif.busy, bif.done, bif.result);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] res;
    int lat, bcnt;
    logic [2:0]  f  [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] va [4] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] vb [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2};
    logic [31:0] ex [4] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], va[i], vb[i], 0, 0, res, lat, bcnt);
      checks++;
      if (res !== ex[i] || lat != 33 || bcnt != 32) begin
        errors++;
        $display("FAIL mul_%0d: result=%h lat=%0d busy=%0d, expected %h 33 32",
                 i, res, lat, bcnt, ex[i]);
      end
      if (i == 0) begin
        @(posedge clk); #1;
        checks++;
        if (bif.done !== 1'b0 || bif.result !== ex[0]) begin
          errors++;
          $display("FAIL done_pulse_width: done=%b result=%h, expected 0 %h",
                   bif.done, bif.result, ex[0]);
        end
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] res;
    int lat, bcnt;
    logic [2:0]  f  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] va [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] vb [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] ex [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], va[i], vb[i], 0, 0, res, lat, bcnt);
      checks++;
      if (res !== ex[i] || lat != 33 || bcnt != 32) begin
        errors++;
        $display("FAIL div_%0d: result=%h lat=%0d busy=%0d, expected %h 33 32",
                 i, res, lat, bcnt, ex[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] res;
    int lat, bcnt;
    logic [2:0]  f  [4] = '{3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] va [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] vb [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0};
    for (int i = 0; i < 4; i++) begin
      run_op(f[i], va[i], vb[i], 0, 0, res, lat, bcnt);
      checks++;
      if (res !== ex[i] || lat != 1 || bcnt != 0) begin
        errors++;
        $display("FAIL special_%0d: result=%h lat=%0d busy=%0d, expected %h 1 0",
                 i, res, lat, bcnt, ex[i]);
      end
    end
  endtask

  task automatic test_ignore_kill();
    logic [31:0] res;
    int lat, bcnt;
    run_op(3'd0, 32'd7, 32'd3, 5, 0, res, lat, bcnt);
    checks++;
    if (res !== 32'd21 || lat != 33 || bcnt != 32) begin
      errors++;
      $display("FAIL start_while_busy: result=%h lat=%0d busy=%0d, expected 00000015 33 32",
               res, lat, bcnt);
    end
    run_op(3'd5, 32'd1000, 32'd3, 0, 10, res, lat, bcnt);
    checks++;
    if (lat != -1 || bcnt != 10 || bif.result !== 32'd21) begin
      errors++;
      $display("FAIL kill_calc: lat=%0d busy=%0d result=%h, expected -1 10 00000015",
               lat, bcnt, bif.result);
    end
    run_op(3'd5, 32'd100, 32'd7, 0, 0, res, lat, bcnt);
    checks++;
    if (res !== 32'd14 || lat != 33) begin
      errors++;
      $display("FAIL after_kill: result=%h lat=%0d, expected 0000000e 33", res, lat);
    end
    @(negedge clk);
    bif.start = 1'b1; bif.kill = 1'b1; bif.funct3 = 3'd4; bif.opA = 32'd5; bif.opB = 32'd0;
    @(posedge clk); #1;
    bif.start = 1'b0; bif.kill = 1'b0;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.result !== 32'd14) begin
      errors++;
      $display("FAIL kill_over_start: busy=%b done=%b result=%h, expected 0 0 0000000e",
               bif.busy, bif.done, bif.result);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    bif.start = 1'b1; bif.funct3 = 3'd3; bif.opA = 32'hFFFFFFFF; bif.opB = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bif.start = 1'b0;
    k = 1;
    while (!bif.done && k < 60) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (k != 33 || bif.result !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d result=%h, expected 33 fffffffe", k, bif.result);
    end
    bif.start = 1'b1; bif.funct3 = 3'd5; bif.opA = 32'd100; bif.opB = 32'd7;
    @(posedge clk); #1;
    bif.start = 1'b0;
    checks++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: done=%b busy=%b, expected 0 1", bif.done, bif.busy);
    end
    k = 1;
    while (!bif.done && k < 60) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (k != 33 || bif.result !== 32'd14) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d result=%h, expected 33 0000000e", k, bif.result);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bif.start = 1'b1; bif.funct3 = 3'd0; bif.opA = 32'd9; bif.opB = 32'd9;
    @(posedge clk); #1;
    bif.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_calc: busy=%b done=%b result=%h, expected 0 0 00000000",
               bif.busy, bif.done, bif.result);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_ignore_kill();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
